// File: rtl/io_pkg.sv
// io_pkg: shared I/O bus address map, switch debounce defaults and FSM state type
package io_pkg;
   localparam logic [31:0] SWITCH_BASE = 32'hFFFFFC70;
   localparam logic [31:0] LED_BASE = 32'hFFFFFC60;
   localparam logic [1:0] SW_LO_OFS = 2'b00;
   localparam logic [1:0] SW_HI_OFS = 2'b10;
   localparam int DEBOUNCE_DEFAULT = 20000;
   typedef enum logic {STABLE, SETTLING} deb_state_t;
endpackage

// File: rtl/switch_debounce.sv
// switch_debounce: two-flop synchronizer plus debounce FSM producing a stable snapshot and a commit pulse
module switch_debounce
   import io_pkg::*;
#(
   parameter int WIDTH = 24,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] stable,
   output logic             commit_changed
);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   logic [WIDTH-1:0] sync1, sync, cand, cand_n, stable_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   deb_state_t state, state_n;
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1 <= '0;
         sync <= '0;
         cand <= '0;
         cnt <= '0;
         stable <= '0;
         state <= STABLE;
      end else begin
         sync1 <= din;
         sync <= sync1;
         cand <= cand_n;
         cnt <= cnt_n;
         stable <= stable_n;
         state <= state_n;
      end
   end
   // A bounce back to the old value still commits, but with cand == stable, so no change is flagged.
   always_comb begin
      state_n = state;
      cand_n = cand;
      cnt_n = cnt;
      stable_n = stable;
      commit_changed = 1'b0;
      if (state == STABLE) begin
         if (sync != stable) begin
            cand_n = sync;
            cnt_n = '0;
            state_n = SETTLING;
         end
      end else if (sync != cand) begin
         cand_n = sync;
         cnt_n = '0;
      end else if (cnt == CNT_MAX) begin
         stable_n = cand;
         cnt_n = '0;
         state_n = STABLE;
         commit_changed = cand != stable;
      end else begin
         cnt_n = cnt + CNT_W'(1);
      end
   end
endmodule

// File: rtl/switch_in.sv
// switch_in: debounced board switch peripheral with sticky change flag and single-cycle read mux
module switch_in
   import io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        switchctrl,
   input  logic [1:0]  switchaddr,
   input  logic        switchread,
   input  logic [23:0] switch_i,
   output logic [15:0] switchrdata
);
   logic [23:0] stable;
   logic commit_changed, changed, rd_lo, rd_hi;
   switch_debounce #(
      .WIDTH(24),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W)
   ) u_deb (
      .clock(clock),
      .reset(reset),
      .din(switch_i),
      .stable(stable),
      .commit_changed(commit_changed)
   );
   assign rd_lo = switchctrl && switchread && switchaddr == SW_LO_OFS;
   assign rd_hi = switchctrl && switchread && switchaddr == SW_HI_OFS;
   // A commit on the same edge as a clearing read wins.
   always_ff @(posedge clock) begin
      if (reset) changed <= 1'b0;
      else if (commit_changed) changed <= 1'b1;
      else if (rd_hi) changed <= 1'b0;
   end
   always_comb begin
      switchrdata = rd_lo ? stable[15:0] : rd_hi ? {changed, 7'b0, stable[23:16]} : 16'h0000;
   end
endmodule

// File: tb/tb_switch_in.sv
// tb_switch_in: directed self-checking bench for switch_in with DEBOUNCE_CYCLES = 4
module tb_switch_in;
   logic clock = 1'b0;
   logic reset, switchctrl, switchread;
   logic [1:0] switchaddr;
   logic [23:0] switch_i;
   logic [15:0] switchrdata;
   int vectors = 0;
   int fails = 0;
   switch_in #(.DEBOUNCE_CYCLES(4)) dut (
      .clock(clock),
      .reset(reset),
      .switchctrl(switchctrl),
      .switchaddr(switchaddr),
      .switchread(switchread),
      .switch_i(switch_i),
      .switchrdata(switchrdata)
   );
   always #5 clock = ~clock;
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask
   task automatic rd(input logic c, input logic r, input logic [1:0] a, input logic [15:0] exp, input bit hold, input string tag);
      switchctrl = c;
      switchread = r;
      switchaddr = a;
      #1;
      vectors++;
      assert (switchrdata === exp) else begin
         fails++;
         $error("FAIL %s: got %h want %h", tag, switchrdata, exp);
      end
      if (hold) step();
      switchctrl = 1'b0;
      switchread = 1'b0;
      switchaddr = 2'b00;
   endtask
   initial begin
      reset = 1'b1;
      switchctrl = 1'b0;
      switchread = 1'b0;
      switchaddr = 2'b00;
      switch_i = 24'hABCDEF;
      step(2);
      reset = 1'b0;
      switch_i = 24'h000000;
      rd(1'b0, 1'b0, 2'b00, 16'h0000, 0, "reset_idle");
      rd(1'b1, 1'b1, 2'b00, 16'h0000, 0, "reset_lo");
      rd(1'b1, 1'b1, 2'b10, 16'h0000, 0, "reset_hi");
      step(2);
      switch_i = 24'h5A1234;
      step(6);
      rd(1'b1, 1'b1, 2'b00, 16'h0000, 0, "clean_before_edge7");
      step();
      rd(1'b1, 1'b1, 2'b00, 16'h1234, 0, "clean_lo");
      rd(1'b1, 1'b1, 2'b10, 16'h805A, 1, "clean_hi_changed");
      rd(1'b1, 1'b1, 2'b10, 16'h005A, 0, "clean_hi_cleared");
      switch_i = 24'h5A1235;
      step(2);
      switch_i = 24'h5A1234;
      step(2);
      switch_i = 24'h5A1235;
      step(6);
      rd(1'b1, 1'b1, 2'b00, 16'h1234, 0, "bounce_not_early");
      rd(1'b1, 1'b1, 2'b10, 16'h005A, 0, "bounce_no_flag_early");
      step();
      rd(1'b1, 1'b1, 2'b00, 16'h1235, 0, "bounce_commit");
      rd(1'b1, 1'b1, 2'b10, 16'h805A, 1, "bounce_changed");
      rd(1'b1, 1'b1, 2'b10, 16'h005A, 0, "bounce_changed_once");
      switch_i = 24'h5A123D;
      step();
      switch_i = 24'h5A1235;
      step(10);
      rd(1'b1, 1'b1, 2'b00, 16'h1235, 0, "glitch_lo");
      rd(1'b1, 1'b1, 2'b10, 16'h005A, 0, "glitch_no_flag");
      switch_i = 24'h5A1236;
      step(6);
      rd(1'b1, 1'b1, 2'b10, 16'h005A, 1, "simul_read_old");
      rd(1'b1, 1'b1, 2'b00, 16'h1236, 0, "simul_lo");
      rd(1'b1, 1'b1, 2'b10, 16'h805A, 1, "simul_set_wins");
      rd(1'b1, 1'b1, 2'b10, 16'h005A, 0, "simul_cleared");
      switch_i = 24'hFFFFFF;
      step(7);
      rd(1'b1, 1'b0, 2'b00, 16'h0000, 1, "gate_noread_lo");
      rd(1'b1, 1'b0, 2'b10, 16'h0000, 1, "gate_noread_hi");
      rd(1'b1, 1'b1, 2'b01, 16'h0000, 1, "gate_addr01");
      rd(1'b1, 1'b1, 2'b11, 16'h0000, 1, "gate_addr11");
      rd(1'b0, 1'b1, 2'b10, 16'h0000, 1, "gate_noctrl");
      rd(1'b1, 1'b1, 2'b00, 16'hFFFF, 1, "gate_lo");
      rd(1'b1, 1'b1, 2'b10, 16'h80FF, 1, "gate_changed_kept");
      rd(1'b1, 1'b1, 2'b10, 16'h00FF, 0, "gate_changed_cleared");
      switch_i = 24'h000000;
      step(4);
      reset = 1'b1;
      step();
      reset = 1'b0;
      rd(1'b1, 1'b1, 2'b00, 16'h0000, 0, "midreset_lo");
      rd(1'b1, 1'b1, 2'b10, 16'h0000, 0, "midreset_hi");
      step(8);
      rd(1'b1, 1'b1, 2'b10, 16'h0000, 0, "midreset_settled");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule

// File: doc/switch_in.md
# switch_in

Switch input peripheral for the single-cycle MIPS32 I/O bus. It synchronizes and debounces the 24 board switches and holds a stable snapshot plus a sticky "changed" flag. It returns 16-bit read data on `switchrdata` when the memory/IO decoder asserts its switch chip-select, and that data feeds the decoder's `ioread_data` input. Reads are combinational from registered state so a `lw` completes in one CPU cycle.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 20000: consecutive stable clocks required before a new switch value is accepted. Must be ≥2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: debounce counter width.

Ports:
- `clock`  in  1  CPU clock; all state updates on the rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `switchctrl`  in  1  Switch chip-select from the decoder; high for `ioread` with address 0xFFFFFC70..0xFFFFFC72.
- `switchaddr`  in  2  `address[1:0]`; 2'b00 selects the low word, 2'b10 selects the high word.
- `switchread`  in  1  `ioread` from the control unit.
- `switch_i`  in  24  Raw asynchronous board switches.
- `switchrdata`  out  16  Read data to the decoder's `ioread_data`.

## Operation
- **Synchronizer.** `switch_i` passes through two flops to form `sync`. Reset clears both flops.
- **Debounce FSM.** The FSM has two states: STABLE and SETTLING. It keeps a `cand[23:0]` register, a `cnt[CNT_W-1:0]` counter, and a `stable[23:0]` snapshot.
  - STABLE, `sync == stable`: hold.
  - STABLE, `sync != stable`: set `cand <= sync`, `cnt <= 0`, go to SETTLING.
  - SETTLING, `sync != cand`: set `cand <= sync`, `cnt <= 0`, stay in SETTLING. This is a bounce restart.
  - SETTLING, `sync == cand` and `cnt == DEBOUNCE_CYCLES-1`: set `stable <= cand`, go to STABLE. If `cand != stable`, set `changed <= 1`.
  - SETTLING, otherwise: `cnt <= cnt+1`.
  - A bounce that returns to the old value still has to be confirmed for the full count. It then commits with `cand == stable`, so `changed` is not set.
- **Read mux** (combinational):
  - `switchctrl && switchread && switchaddr == 2'b00` → `stable[15:0]`.
  - `switchctrl && switchread && switchaddr == 2'b10` → `{changed, 7'b0, stable[23:16]}`.
  - Any other condition, including `switchaddr` 2'b01 or 2'b11 → 16'h0000.
- **Clear-on-read.** At the clock edge ending a selected read of 2'b10, `changed <= 0`.
  - If a commit that sets `changed` occurs on the same edge, the set wins and `changed` stays 1.
- The read data is the pre-edge value, so the reading instruction sees `changed = 1` and it clears afterwards.
- Reads of 2'b00 do not affect `changed`.

## Timing
- Reset values:
  - Synchronizer flops, `cand`, `stable`: 0.
  - `cnt`: 0.
  - FSM state: STABLE.
  - `changed`: 0.
  - `switchrdata`: 16'h0000, since it is combinational and reads are not selected.
- Reset asserted mid-SETTLING aborts the pending value. Any in-flight commit is lost.
- Latency from a `switch_i` change to `stable` update, with no bounce: 2 clocks synchronizer + 1 clock to enter SETTLING + `DEBOUNCE_CYCLES` clocks of counting. With `DEBOUNCE_CYCLES = N`, `stable` changes on edge N+3 after the input change.
- `switchrdata` updates in the same cycle as `switchctrl`/`switchaddr`, with zero-cycle latency. It never depends on `switch_i` combinationally.
- The counter never wraps: it restarts at 0 on any commit or candidate change.

## Structure
- Shared package `io_pkg`:
  - `SWITCH_BASE = 32'hFFFFFC70`
  - `LED_BASE = 32'hFFFFFC60`
  - `SW_LO_OFS = 2'b00`, `SW_HI_OFS = 2'b10`
  - Default `DEBOUNCE_CYCLES`
  - Enum for the FSM states {STABLE, SETTLING}
- One sub-module, `switch_debounce`. It contains the synchronizer and the debounce FSM, takes `WIDTH`/`DEBOUNCE_CYCLES` parameters, and outputs `stable` plus a one-cycle `commit_changed` pulse.
- The top level holds `changed` and the read mux.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4`.
- **Reset.** Hold `reset` 2 cycles with `switch_i = 24'hABCDEF`, then read 2'b00 → 16'h0000 in the cycle after reset. Read 2'b10 → 16'h0000.
- **Clean change.** From `stable = 0`, set `switch_i = 24'h5A1234`. Before edge 7, `stable` is still 0. After edge 7, read 2'b00 → 16'h1234 and read 2'b10 → 16'h805A. A second 2'b10 read → 16'h005A.
- **Bounce.** Toggle `switch_i[0]` 0→1→0→1 with 2-cycle spacing, then hold at 1. `stable[0]` rises exactly N+3 edges after the last toggle, never earlier. `changed` is set once.
- **Glitch back to old value.** Pulse `switch_i[3]` high for 1 cycle with `stable = 0`. `stable` stays 0 and `changed` stays 0.
- **Simultaneous set/clear.** Align a commit of a new value with a 2'b10 read in the same cycle. The read returns the old `changed`, and afterwards `changed == 1`.
- **Decode gating.** `switchctrl = 1, switchread = 0`, or `switchaddr = 2'b01`, with `stable = 24'hFFFFFF` → `switchrdata == 16'h0000` and `changed` is unchanged.
